sync_fifo_reader: RTL and testbench

//  Read-side drain engine for sync_fifo. Pops words via fifo_pull and presents

---
 rtl/sync_fifo_reader_if.sv | 22 ++
 rtl/sync_fifo_reader.sv | 98 +++++++++
 tb/tb_sync_fifo_reader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_reader_if.sv
// Handshake bundle for sync_fifo_reader: the FIFO read port (empty/data/pull)
// and the registered valid/ready master stream toward the channel driver.
interface sync_fifo_reader_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_pull;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_pull, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_pull, m_valid, m_data
  );
endinterface

// File: rtl/sync_fifo_reader.sv
// Drains sync_fifo into a registered valid/ready stream via a head+skid buffer.
// Optional accepted-beat counter enabled by defining SYNC_FIFO_RD_CNT_EN.
module sync_fifo_reader #(
  parameter int DATA_WIDTH = 16
`ifdef SYNC_FIFO_RD_CNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 srst,
  sync_fifo_reader_if.master   bus
`ifdef SYNC_FIFO_RD_CNT_EN
  , output logic [CNT_WIDTH-1:0] beat_cnt
`endif
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  occ_e                  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  push, pop;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  // Pull depends only on registered occupancy, keeping m_ready off this path.
  always_comb begin
    push   = !srst && !bus.fifo_empty && (occ_q != OCC_FULL);
    pop    = (occ_q != OCC_EMPTY) && bus.m_ready;
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    if (srst) begin
      occ_d  = OCC_EMPTY;
      head_d = '0;
      skid_d = '0;
    end else begin
      case (occ_q)
        OCC_EMPTY: if (push) begin
          head_d = bus.fifo_data;
          occ_d  = OCC_ONE;
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_d = bus.fifo_data;
          end else if (push) begin
            skid_d = bus.fifo_data;
            occ_d  = OCC_FULL;
          end else if (pop) begin
            occ_d  = OCC_EMPTY;
          end
        end
        OCC_FULL: if (pop) begin
          head_d = skid_q;
          occ_d  = OCC_ONE;
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  assign bus.fifo_pull = push;
  assign bus.m_valid   = (occ_q != OCC_EMPTY);
  assign bus.m_data    = head_q;

`ifdef SYNC_FIFO_RD_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (srst)     cnt_d = '0;
    else if (pop) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign beat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Bench for sync_fifo_reader: upstream FIFO and a 2-word output buffer kept as
// queues; every cycle the DUT outputs are compared to that model.
module tb_sync_fifo_reader;
  localparam int DW = 16;
  localparam int CW = 4;

  logic aclk = 1'b0;
  logic aresetn;
  logic srst;
  always #5 aclk = ~aclk;

  sync_fifo_reader_if #(.DATA_WIDTH(DW)) bus ();

`ifdef SYNC_FIFO_RD_CNT_EN
  logic [CW-1:0] beat_cnt;
  sync_fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .bus(bus), .beat_cnt(beat_cnt));
`else
  sync_fifo_reader #(.DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .bus(bus));
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mcnt   = 0;

  logic [DW-1:0] fq[$];    // upstream FIFO contents
  logic [DW-1:0] mbuf[$];  // words the reader should be holding, head first
  logic [DW-1:0] got[$];   // words accepted downstream
  logic [DW-1:0] sent[$];
  int            pop_cyc[$];

  logic          last_pull, last_valid;
  logic [DW-1:0] last_data;
  logic [CW-1:0] last_cnt;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, compare after settling, advance model at posedge.
  task automatic step(input logic rstn, input logic sr, input logic rdy);
    logic          exp_pull, exp_pop;
    logic [DW-1:0] pdata;
    @(negedge aclk);
    aresetn        = rstn;
    srst           = sr;
    bus.m_ready    = rdy;
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_data  = (fq.size() == 0) ? DW'($urandom) : fq[0];
    if (!rstn) begin
      mbuf.delete();
      mcnt = 0;
    end
    #1;
    exp_pull = !sr && (fq.size() != 0) && (mbuf.size() < 2);
    exp_pop  = rstn && !sr && (mbuf.size() != 0) && rdy;
    check("m_valid", 32'(bus.m_valid), 32'(mbuf.size() != 0));
    check("fifo_pull", 32'(bus.fifo_pull), 32'(exp_pull));
    if (mbuf.size() != 0) check("m_data", 32'(bus.m_data), 32'(mbuf[0]));
    if (prev_stall && rstn) begin
      check("stall_valid", 32'(bus.m_valid), 32'd1);
      check("stall_data", 32'(bus.m_data), 32'(prev_data));
    end
`ifdef SYNC_FIFO_RD_CNT_EN
    check("beat_cnt", 32'(beat_cnt), 32'(mcnt));
    last_cnt = beat_cnt;
`else
    last_cnt = '0;
`endif
    last_pull  = bus.fifo_pull;
    last_valid = bus.m_valid;
    last_data  = bus.m_data;
    prev_stall = bus.m_valid && !rdy && rstn && !sr;
    prev_data  = bus.m_data;
    pdata      = (fq.size() != 0) ? fq[0] : '0;
    @(posedge aclk);
    if (exp_pull) void'(fq.pop_front());
    if (!rstn || sr) begin
      mbuf.delete();
      mcnt = 0;
    end else begin
      if (exp_pop) begin
        got.push_back(mbuf.pop_front());
        pop_cyc.push_back(cyc);
        mcnt = (mcnt + 1) % (1 << CW);
      end
      if (exp_pull) mbuf.push_back(pdata);
    end
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((fq.size() != 0 || mbuf.size() != 0) && n < 200) begin
      step(1'b1, 1'b0, 1'b1);
      n++;
    end
    check("drain_timeout", 32'(fq.size() + mbuf.size()), 32'd0);
  endtask

  initial begin
    int npull, bad, n;
    logic seen_ab, seen_c;
    aresetn        = 1'b0;
    srst           = 1'b1;
    bus.m_ready    = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;

    // Reset with three words waiting upstream
    fq = '{16'h0101, 16'h0202, 16'h0303};
    step(1'b0, 1'b1, 1'b0);
    check("rst_valid", 32'(last_valid), 32'd0);
    check("rst_pull", 32'(last_pull), 32'd0);
    check("rst_data", 32'(last_data), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("rel_pull", 32'(last_pull), 32'd1);
    check("rel_valid", 32'(last_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("rel_valid2", 32'(last_valid), 32'd1);
    check("rel_data2", 32'(last_data), 32'h0101);
    drain();

    // Streaming 0x0001..0x0010 with m_ready high
    got.delete(); pop_cyc.delete();
    for (int i = 1; i <= 16; i++) fq.push_back(DW'(i));
    repeat (20) step(1'b1, 1'b0, 1'b1);
    check("stream_count", 32'(got.size()), 32'd16);
    bad = 0;
    for (int i = 0; i < got.size(); i++) begin
      if (got[i] !== DW'(i + 1)) bad++;
      if (pop_cyc[i] != pop_cyc[0] + i) bad++;
    end
    check("stream_order_gapless", 32'(bad), 32'd0);

    // Backpressure with five words queued
    got.delete();
    for (int i = 1; i <= 5; i++) fq.push_back(DW'(i));
    npull = 0;
    repeat (6) begin
      step(1'b1, 1'b0, 1'b0);
      npull += int'(last_pull);
    end
    check("bp_pulls", 32'(npull), 32'd2);
    check("bp_head", 32'(last_data), 32'h0001);
    drain();
    bad = (got.size() == 5) ? 0 : 1;
    for (int i = 0; i < got.size(); i++) if (got[i] !== DW'(i + 1)) bad++;
    check("bp_order", 32'(bad), 32'd0);

    // srst with both slots full; a further word waits upstream
    got.delete();
    fq = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    repeat (3) step(1'b1, 1'b0, 1'b0);
    check("full_valid", 32'(last_valid), 32'd1);
    check("full_head", 32'(last_data), 32'hAAAA);
    step(1'b1, 1'b1, 1'b1);
    check("srst_pull_full", 32'(last_pull), 32'd0);
    step(1'b1, 1'b1, 1'b1);
    check("srst_pull_nonempty", 32'(last_pull), 32'd0);
    check("srst_valid", 32'(last_valid), 32'd0);
    check("srst_data", 32'(last_data), 32'd0);
    drain();
    seen_ab = 1'b0; seen_c = 1'b0;
    foreach (got[i]) begin
      if (got[i] == 16'hAAAA || got[i] == 16'hBBBB) seen_ab = 1'b1;
      if (got[i] == 16'hCCCC) seen_c = 1'b1;
    end
    check("srst_discard", 32'(seen_ab), 32'd0);
    check("srst_next_word", 32'(seen_c), 32'd1);

    // Random m_ready and random FIFO arrivals, 1000 words
    got.delete(); sent.delete();
    n = 0;
    while ((sent.size() < 1000 || fq.size() != 0 || mbuf.size() != 0) && n < 20000) begin
      if (sent.size() < 1000 && $urandom_range(0, 3) != 0) begin
        logic [DW-1:0] w;
        w = DW'($urandom);
        fq.push_back(w);
        sent.push_back(w);
      end
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      n++;
    end
    bad = (got.size() == sent.size()) ? 0 : 1;
    for (int i = 0; i < got.size() && i < sent.size(); i++) if (got[i] !== sent[i]) bad++;
    check("random_scoreboard", 32'(bad), 32'd0);
    check("random_count", 32'(got.size()), 32'd1000);

    // Asynchronous reset with words buffered
    fq = '{16'h1111, 16'h2222, 16'h3333};
    repeat (2) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("arst_valid", 32'(last_valid), 32'd0);
    check("arst_data", 32'(last_data), 32'd0);
    drain();

`ifdef SYNC_FIFO_RD_CNT_EN
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) fq.push_back(DW'(i));
    drain();
    step(1'b1, 1'b0, 1'b0);
    check("cnt_wrap", 32'(last_cnt), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("cnt_srst", 32'(last_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
